// File: rtl/imem_loader.sv
// Boot-time program loader: parses a length-prefixed byte stream into little-endian
// 32-bit words, writes them sequentially into IMem and holds the core until done.
//
// state  | meaning
// S_LEN0 | waiting for low byte of the word count
// S_LEN1 | waiting for high byte of the word count
// S_DATA | assembling data words, four bytes LSB first
// S_DONE | frame complete; stream stalled until load_start

module imem_loader #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  load_start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  overflow,
   output logic [15:0]           word_count
);

   typedef enum logic [1:0] {
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

   state_t      state;
   state_t      state_next;
   logic [1:0]  byte_idx;
   logic [15:0] word_idx;
   logic [23:0] shift_buf;
   logic        accept;
   logic        word_end;
   logic        last_word;
   logic        in_range;
   logic        len_zero;

   always_comb begin
      state_next = state;
      in_ready   = (state != S_DONE);
      accept     = in_valid && in_ready;
      word_end   = accept && (state == S_DATA) && (byte_idx == 2'd3);
      last_word  = ({1'b0, word_idx} + 17'd1) == {1'b0, word_count};
      in_range   = {1'b0, word_idx} < DEPTH;
      len_zero   = ({in_data, word_count[7:0]} == 16'd0);
      case (state)
         S_LEN0: if (accept) state_next = S_LEN1;
         S_LEN1: if (accept) state_next = len_zero ? S_DONE : S_DATA;
         S_DATA: if (word_end && last_word) state_next = S_DONE;
         S_DONE: if (load_start) state_next = S_LEN0;
         default: state_next = S_LEN0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_LEN0;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx   <= 2'd0;
         word_idx   <= 16'd0;
         shift_buf  <= 24'd0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         overflow   <= 1'b0;
         word_count <= 16'd0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_LEN0: begin
               if (accept) word_count[7:0] <= in_data;
            end
            S_LEN1: begin
               if (accept) begin
                  word_count[15:8] <= in_data;
                  byte_idx         <= 2'd0;
                  word_idx         <= 16'd0;
                  if (len_zero) done <= 1'b1;
               end
            end
            S_DATA: begin
               if (accept) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: shift_buf[7:0]   <= in_data;
                     2'd1: shift_buf[15:8]  <= in_data;
                     2'd2: shift_buf[23:16] <= in_data;
                     default: begin
                        // Words beyond IMem depth are drained from the stream but never written.
                        if (in_range) begin
                           imem_we    <= 1'b1;
                           imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                           imem_wdata <= {in_data, shift_buf};
                        end else begin
                           overflow <= 1'b1;
                        end
                        word_idx <= word_idx + 16'd1;
                        if (last_word) done <= 1'b1;
                     end
                  endcase
               end
            end
            S_DONE: begin
               if (load_start) begin
                  done     <= 1'b0;
                  overflow <= 1'b0;
                  word_idx <= 16'd0;
                  cpu_hold <= 1'b1;
               end else if (done) begin
                  // Release one cycle after done so the final write has landed.
                  cpu_hold <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
